// File: rtl/ram_fifo_arbiter.sv
// Round-robin write scheduler and in-order drain controller for a shared dual-port RAM buffer.
// Each buffered entry carries the index of the requester that produced it.
module ram_fifo_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = 2,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_SIZE  = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_REQ-1:0]             s_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  s_data_i,
  output logic [NUM_REQ-1:0]             s_ready_o,
  output logic                           ram_wr_en_o,
  output logic [ADDR_SIZE-1:0]           ram_wr_addr_o,
  output logic [ID_WIDTH+DATA_WIDTH-1:0] ram_wr_data_o,
  output logic                           ram_full_o,
  output logic [ADDR_SIZE-1:0]           ram_rd_addr_o,
  input  logic [ID_WIDTH+DATA_WIDTH-1:0] ram_rd_data_i,
  output logic                           m_valid_o,
  output logic [ID_WIDTH-1:0]            m_id_o,
  output logic [DATA_WIDTH-1:0]          m_data_o,
  input  logic                           m_ready_i,
  output logic [ADDR_SIZE:0]             count_o
);

  localparam logic [ADDR_SIZE:0] DEPTH   = {1'b1, {ADDR_SIZE{1'b0}}};
  localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(NUM_REQ - 1);

  logic [ADDR_SIZE:0]    wr_ptr_q, wr_ptr_d;
  logic [ADDR_SIZE:0]    rd_ptr_q, rd_ptr_d;
  logic [ADDR_SIZE:0]    count_q, count_d;
  logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;

  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  found;
  int                    idx;
  logic [NUM_REQ-1:0]    grant;
  logic [ID_WIDTH-1:0]   grant_id;
  logic [DATA_WIDTH-1:0] grant_data;

  assign full  = (count_q == DEPTH);
  assign empty = (count_q == '0);

  // Reset suppresses all grants so nothing is accepted while the pointers clear.
  always_comb begin
    grant      = '0;
    grant_id   = '0;
    grant_data = '0;
    found      = 1'b0;
    idx        = 0;
    if (!rst_i && !full) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = (int'(rr_ptr_q) + k) % NUM_REQ;
        if (!found && s_valid_i[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          grant_id   = ID_WIDTH'(idx);
          grant_data = s_data_i[idx*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  assign push = |grant;
  assign pop  = !rst_i && !empty && m_ready_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rr_ptr_d = rr_ptr_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      rr_ptr_d = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign s_ready_o     = grant;
  assign ram_wr_en_o   = push;
  assign ram_wr_addr_o = wr_ptr_q[ADDR_SIZE-1:0];
  assign ram_wr_data_o = {grant_id, grant_data};
  assign ram_full_o    = full;
  assign ram_rd_addr_o = rd_ptr_q[ADDR_SIZE-1:0];
  assign m_valid_o     = !empty;
  assign m_id_o        = ram_rd_data_i[ID_WIDTH+DATA_WIDTH-1 -: ID_WIDTH];
  assign m_data_o      = ram_rd_data_i[DATA_WIDTH-1:0];
  assign count_o       = count_q;

endmodule
